// File: rtl/data_interconnect_ctrl_if.sv
// data_interconnect_ctrl_if: layer command, stream monitor taps and sequencer status bundle.
interface data_interconnect_ctrl_if #(parameter int CNT_W = 16);
  logic             s_cmd_tvalid;
  logic             s_cmd_tready;
  logic             s_cmd_mode;
  logic [CNT_W-1:0] s_cmd_f_pkts;
  logic [CNT_W-1:0] s_cmd_h_pkts;
  logic             f_mon_valid;
  logic             f_mon_ready;
  logic             f_mon_last;
  logic             h_mon_valid;
  logic             h_mon_ready;
  logic             h_mon_last;
  logic             conv_idle;
  logic             mode;
  logic             f_gate;
  logic             h_gate;
  logic             busy;
  logic             layer_done;
  logic [CNT_W-1:0] f_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic             err;
  modport master (
    output s_cmd_tvalid, s_cmd_mode, s_cmd_f_pkts, s_cmd_h_pkts,
    output f_mon_valid, f_mon_ready, f_mon_last, h_mon_valid, h_mon_ready, h_mon_last, conv_idle,
    input  s_cmd_tready, mode, f_gate, h_gate, busy, layer_done, f_cnt, h_cnt, err
  );
  modport slave (
    input  s_cmd_tvalid, s_cmd_mode, s_cmd_f_pkts, s_cmd_h_pkts,
    input  f_mon_valid, f_mon_ready, f_mon_last, h_mon_valid, h_mon_ready, h_mon_last, conv_idle,
    output s_cmd_tready, mode, f_gate, h_gate, busy, layer_done, f_cnt, h_cnt, err
  );
endinterface

// File: rtl/data_interconnect_ctrl.sv
// data_interconnect_ctrl: layer sequencer that gates f/h packets to a commanded count, then drains.
module data_interconnect_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 8,
  parameter int DRAIN_W      = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  data_interconnect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               f_gate_q, f_gate_d, h_gate_q, h_gate_d;
  logic               rdy_q, busy_q, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]   f_tgt_q, f_tgt_d, h_tgt_q, h_tgt_d;
  logic [CNT_W-1:0]   f_cnt_q, f_cnt_d, h_cnt_q, h_cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d, drain_nxt;
  logic               f_tl, h_tl, f_pkt, h_pkt, accept;
  assign f_tl   = bus.f_mon_valid & bus.f_mon_ready & bus.f_mon_last;
  assign h_tl   = bus.h_mon_valid & bus.h_mon_ready & bus.h_mon_last;
  assign f_pkt  = f_tl & f_gate_q;
  assign h_pkt  = h_tl & h_gate_q;
  assign accept = (state_q == IDLE) & bus.s_cmd_tvalid & rdy_q;
  // The drain exits on the cycle its counter reaches zero, so a full drain spans DRAIN_CYCLES cycles.
  assign drain_nxt = drain_q - DRAIN_W'(drain_q != '0);
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    f_tgt_d  = f_tgt_q;
    h_tgt_d  = h_tgt_q;
    f_cnt_d  = f_cnt_q;
    h_cnt_d  = h_cnt_q;
    f_gate_d = f_gate_q;
    h_gate_d = h_gate_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    err_d    = err_q | (f_tl & ~f_gate_q) | (h_tl & ~h_gate_q);
    case (state_q)
      IDLE: if (accept) begin
        state_d  = RUN;
        mode_d   = bus.s_cmd_mode;
        f_tgt_d  = bus.s_cmd_f_pkts;
        h_tgt_d  = bus.s_cmd_h_pkts;
        f_cnt_d  = '0;
        h_cnt_d  = '0;
        f_gate_d = |bus.s_cmd_f_pkts;
        h_gate_d = |bus.s_cmd_h_pkts;
      end
      RUN: if (f_cnt_q == f_tgt_q && h_cnt_q == h_tgt_q) begin
        state_d = DRAIN;
        drain_d = DRAIN_W'(DRAIN_CYCLES);
      end else begin
        f_cnt_d  = f_cnt_q + CNT_W'(f_pkt);
        h_cnt_d  = h_cnt_q + CNT_W'(h_pkt);
        f_gate_d = f_gate_q & (f_cnt_d != f_tgt_q);
        h_gate_d = h_gate_q & (h_cnt_d != h_tgt_q);
      end
      DRAIN: begin
        drain_d = drain_nxt;
        if (drain_nxt == '0 && (!mode_q || bus.conv_idle)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      f_tgt_q  <= '0;
      h_tgt_q  <= '0;
      f_cnt_q  <= '0;
      h_cnt_q  <= '0;
      f_gate_q <= 1'b0;
      h_gate_q <= 1'b0;
      drain_q  <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      f_tgt_q  <= f_tgt_d;
      h_tgt_q  <= h_tgt_d;
      f_cnt_q  <= f_cnt_d;
      h_cnt_q  <= h_cnt_d;
      f_gate_q <= f_gate_d;
      h_gate_q <= h_gate_d;
      drain_q  <= drain_d;
      rdy_q    <= state_d == IDLE;
      busy_q   <= state_d != IDLE;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign bus.s_cmd_tready = rdy_q;
  assign bus.mode         = mode_q;
  assign bus.f_gate       = f_gate_q;
  assign bus.h_gate       = h_gate_q;
  assign bus.busy         = busy_q;
  assign bus.layer_done   = done_q;
  assign bus.f_cnt        = f_cnt_q;
  assign bus.h_cnt        = h_cnt_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_data_interconnect_ctrl.sv
// tb_data_interconnect_ctrl: random-stimulus bench against a layer-level reference model.
module tb_data_interconnect_ctrl;
  localparam int CNT_W = 16;
  localparam int DRAIN = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  data_interconnect_ctrl_if #(.CNT_W(CNT_W)) bus ();
  data_interconnect_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN), .DRAIN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int vecs = 0;
  int errs = 0;
  int phase, f_tgt, h_tgt, f_seen, h_seen, drain_age, ci_at, cf, ch;
  bit exp_rdy, exp_mode, f_open, h_open, exp_done, exp_err, cv, cm, frc_pend;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("tready", 32'(bus.s_cmd_tready), 32'(exp_rdy));
    check("mode", 32'(bus.mode), 32'(exp_mode));
    check("f_gate", 32'(bus.f_gate), 32'(f_open));
    check("h_gate", 32'(bus.h_gate), 32'(h_open));
    check("busy", 32'(bus.busy), 32'(phase != 0));
    check("layer_done", 32'(bus.layer_done), 32'(exp_done));
    check("f_cnt", 32'(bus.f_cnt), 32'(f_seen));
    check("h_cnt", 32'(bus.h_cnt), 32'(h_seen));
    check("err", 32'(bus.err), 32'(exp_err));
  endtask
  task automatic model_zero();
    phase = 0; f_tgt = 0; h_tgt = 0; f_seen = 0; h_seen = 0; drain_age = 0;
    exp_rdy = 0; exp_mode = 0; f_open = 0; h_open = 0; exp_done = 0; exp_err = 0;
  endtask
  task automatic drive_and_model();
    bit fv, fr, fl, hv, hr, hl, ci, ftl, htl;
    fr = ($urandom % 4) != 0;
    fl = 1'($urandom % 2);
    fv = f_open && ($urandom % 2);
    hr = ($urandom % 4) != 0;
    hl = 1'($urandom % 2);
    hv = h_open && ($urandom % 2);
    if (frc_pend && phase == 1 && !f_open && f_tgt != 0) begin
      fv = 1; fr = 1; fl = 1; frc_pend = 0;
    end
    ci = (phase == 2) ? (drain_age >= ci_at) : 1'($urandom % 2);
    bus.s_cmd_tvalid = cv;
    bus.s_cmd_mode   = cm;
    bus.s_cmd_f_pkts = CNT_W'(cf);
    bus.s_cmd_h_pkts = CNT_W'(ch);
    bus.f_mon_valid  = fv;
    bus.f_mon_ready  = fr;
    bus.f_mon_last   = fl;
    bus.h_mon_valid  = hv;
    bus.h_mon_ready  = hr;
    bus.h_mon_last   = hl;
    bus.conv_idle    = ci;
    ftl = fv & fr & fl;
    htl = hv & hr & hl;
    exp_err = exp_err | (ftl & !f_open) | (htl & !h_open);
    exp_done = 0;
    if (phase == 0) begin
      if (cv && exp_rdy) begin
        exp_mode = cm; f_tgt = cf; h_tgt = ch; f_seen = 0; h_seen = 0;
        f_open = f_tgt != 0; h_open = h_tgt != 0; phase = 1;
      end
    end else if (phase == 1) begin
      if (f_seen == f_tgt && h_seen == h_tgt) begin
        phase = 2; drain_age = 1;
      end else begin
        if (ftl && f_open) begin f_seen++; f_open = f_seen != f_tgt; end
        if (htl && h_open) begin h_seen++; h_open = h_seen != h_tgt; end
      end
    end else begin
      if (drain_age >= DRAIN && (!exp_mode || ci)) begin
        phase = 0; exp_done = 1;
      end else drain_age++;
    end
    exp_rdy = phase == 0;
  endtask
  task automatic step();
    @(negedge clk);
    check_all();
    drive_and_model();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_zero();
    #1 check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    drive_and_model();
  endtask
  task automatic run_layer(input bit m, input int f, input int h, input int cat, input bit frc,
                           input bit hold, input bit nm, input int nf, input int nh, input bit midrst);
    int n;
    cm = m; cf = f; ch = h; cv = 1; ci_at = cat; frc_pend = frc;
    n = 0;
    while (phase != 1 && n < 100) begin step(); n++; end
    check("accept_within_bound", 32'(n < 100), 1);
    cv = hold;
    if (hold) begin cm = nm; cf = nf; ch = nh; end
    n = 0;
    while (!exp_done && n < 500) begin
      step();
      n++;
      if (midrst && phase == 1 && f_seen == 1) begin
        cv = 0; frc_pend = 0;
        #3 do_reset();
        return;
      end
    end
    check("done_within_bound", 32'(n < 500), 1);
  endtask
  initial begin
    cv = 0; cm = 0; cf = 0; ch = 0; frc_pend = 0; ci_at = 0;
    model_zero();
    #2 do_reset();
    run_layer(1, 3, 2, 20, 0, 0, 0, 0, 0, 0);
    run_layer(0, 3, 2, 20, 0, 0, 0, 0, 0, 0);
    run_layer(0, 0, 0, 20, 0, 0, 0, 0, 0, 0);
    run_layer(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    run_layer(0, 3, 1, 0, 1, 0, 0, 0, 0, 0);
    run_layer(0, 2, 2, 5, 0, 1, 1, 4, 1, 0);
    run_layer(1, 4, 1, 5, 0, 0, 0, 0, 0, 0);
    run_layer(1, 3, 3, 0, 0, 0, 0, 0, 0, 1);
    run_layer(0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (30)
      run_layer(1'($urandom % 2), int'($urandom % 5), int'($urandom % 5), int'($urandom % 14),
                ($urandom % 6) == 0, 1'($urandom % 2), 1'($urandom % 2), int'($urandom % 4),
                int'($urandom % 4), 0);
    cv = 0;
    repeat (40) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
